// File: rtl/axi_store_unit.sv
// Purpose : MEM-stage store master; one single-beat AXI4 write (AW/W/B) per store request.
// Latency : accept -> done in 3 cycles minimum (AW/W at +1, B at +2); misaligned rejected in 1 cycle.
// Backpres: req_ready low while a store is in flight; AW and W each hold until their own ready.
//
// Optional feature macro: STORE_POSTED_EN
//    defined   - done pulses after the AW/W handshakes; up to two B responses collected in background
//    undefined - done pulses only after the B response (non-posted)
//
// Ports:
//    clk, reset          clock, synchronous active-high reset
//    req_*               store request from the pipeline (valid/ready, addr, right-aligned data, size)
//    done, misalign      one-cycle retire pulse; misalign marks a rejected unaligned request
//    bus_err             sticky error flag, set by any non-OKAY B response, cleared by reset
//    m_axi_aw*/w*/b*     AXI4 write channels of the shared master port
module axi_store_unit #(
   parameter int ID_WIDTH   = 13,
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 64,
   parameter int WR_ID      = 1
) (
   input  logic                    clk,
   input  logic                    reset,

   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic [DATA_WIDTH-1:0]   req_data,
   input  logic [1:0]              req_size,

   output logic                    done,
   output logic                    misalign,
   output logic                    bus_err,

   output logic [ID_WIDTH-1:0]     m_axi_awid,
   output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
   output logic [7:0]              m_axi_awlen,
   output logic [2:0]              m_axi_awsize,
   output logic [1:0]              m_axi_awburst,
   output logic                    m_axi_awlock,
   output logic [3:0]              m_axi_awcache,
   output logic [2:0]              m_axi_awprot,
   output logic                    m_axi_awvalid,
   input  logic                    m_axi_awready,

   output logic [DATA_WIDTH-1:0]   m_axi_wdata,
   output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
   output logic                    m_axi_wlast,
   output logic                    m_axi_wvalid,
   input  logic                    m_axi_wready,

   input  logic [ID_WIDTH-1:0]     m_axi_bid,
   input  logic [1:0]              m_axi_bresp,
   input  logic                    m_axi_bvalid,
   output logic                    m_axi_bready
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t state, state_nxt;

   // Request captured at accept; these registers drive AW/W directly so the
   // payload is stable for as long as the valids are up.
   logic [ADDR_WIDTH-1:0]  addr_q;
   logic [1:0]             size_q;
   logic [DATA_WIDTH-1:0]  wdata_q;
   logic [STRB_WIDTH-1:0]  wstrb_q;

   // Per-channel "handshake already happened" flags for the current request.
   logic aw_sent, w_sent;

   logic done_q, misalign_q, bus_err_q;

   logic aw_hs, w_hs, b_hs;
   logic accept;
   logic req_unaligned;
   logic issue_done;
   logic retire;

   logic [2:0]            align_mask;
   logic [7:0]            strb_base;
   logic [DATA_WIDTH-1:0] data_masked;

   // bid is deliberately ignored: only one write ID is ever issued.
   logic unused_bid;
   assign unused_bid = ^m_axi_bid;

`ifdef STORE_POSTED_EN
   // Writes whose AW/W are done but whose B response has not arrived yet.
   logic [1:0] out_cnt;
`endif

   // ----------------------------------------------------------------------
   // Request decode: alignment mask, lane strobe and data masking by size
   // ----------------------------------------------------------------------
   always_comb begin
      align_mask  = 3'b000;
      strb_base   = 8'h01;
      data_masked = '0;
      case (req_size)
         2'd0: begin
            align_mask  = 3'b000;
            strb_base   = 8'h01;
            data_masked = {{(DATA_WIDTH-8){1'b0}},  req_data[7:0]};
         end
         2'd1: begin
            align_mask  = 3'b001;
            strb_base   = 8'h03;
            data_masked = {{(DATA_WIDTH-16){1'b0}}, req_data[15:0]};
         end
         2'd2: begin
            align_mask  = 3'b011;
            strb_base   = 8'h0F;
            data_masked = {{(DATA_WIDTH-32){1'b0}}, req_data[31:0]};
         end
         default: begin
            align_mask  = 3'b111;
            strb_base   = 8'hFF;
            data_masked = req_data;
         end
      endcase
   end

   assign req_unaligned = |(req_addr[2:0] & align_mask);
   assign accept        = req_valid && req_ready;

   assign aw_hs = m_axi_awvalid && m_axi_awready;
   assign w_hs  = m_axi_wvalid  && m_axi_wready;
   assign b_hs  = m_axi_bvalid  && m_axi_bready;

   // Both channels finished, counting a handshake that lands this cycle.
   assign issue_done = (state == ISSUE) && (aw_sent || aw_hs) && (w_sent || w_hs);

`ifdef STORE_POSTED_EN
   assign retire = issue_done;
`else
   assign retire = (state == RESP) && b_hs;
`endif

   // ----------------------------------------------------------------------
   // FSM: next state and channel controls
   // ----------------------------------------------------------------------
   always_comb begin
      state_nxt     = state;
      req_ready     = 1'b0;
      m_axi_awvalid = 1'b0;
      m_axi_wvalid  = 1'b0;
      m_axi_bready  = 1'b0;

      case (state)
         IDLE: begin
`ifdef STORE_POSTED_EN
            req_ready = (out_cnt < 2'd2);
`else
            req_ready = 1'b1;
`endif
            if (accept && !req_unaligned) begin
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            m_axi_awvalid = !aw_sent;
            m_axi_wvalid  = !w_sent;
            if (issue_done) begin
`ifdef STORE_POSTED_EN
               state_nxt = IDLE;
`else
               state_nxt = RESP;
`endif
            end
         end
         RESP: begin
            m_axi_bready = 1'b1;
            if (m_axi_bvalid) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

`ifdef STORE_POSTED_EN
      // B is drained in the background, independent of the FSM state.
      m_axi_bready = (out_cnt != 2'd0);
`endif
   end

   // ----------------------------------------------------------------------
   // Sequential state
   // ----------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         addr_q     <= '0;
         size_q     <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         aw_sent    <= 1'b0;
         w_sent     <= 1'b0;
         done_q     <= 1'b0;
         misalign_q <= 1'b0;
         bus_err_q  <= 1'b0;
      end else begin
         state <= state_nxt;

         if (accept && !req_unaligned) begin
            addr_q  <= req_addr;
            size_q  <= req_size;
            wdata_q <= data_masked << {req_addr[2:0], 3'b000};
            wstrb_q <= strb_base << req_addr[2:0];
         end

         // Flags are cleared whenever we leave ISSUE so the next request
         // starts with both channels pending.
         if (state != ISSUE || issue_done) begin
            aw_sent <= 1'b0;
            w_sent  <= 1'b0;
         end else begin
            if (aw_hs) aw_sent <= 1'b1;
            if (w_hs)  w_sent  <= 1'b1;
         end

         done_q     <= retire || (accept && req_unaligned);
         misalign_q <= accept && req_unaligned;

         if (b_hs && (m_axi_bresp != 2'b00)) begin
            bus_err_q <= 1'b1;
         end
      end
   end

`ifdef STORE_POSTED_EN
   // A completion and a B response in the same cycle cancel out.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_cnt <= 2'd0;
      end else begin
         case ({issue_done, b_hs})
            2'b10:   out_cnt <= out_cnt + 2'd1;
            2'b01:   out_cnt <= out_cnt - 2'd1;
            default: out_cnt <= out_cnt;
         endcase
      end
   end
`endif

   // ----------------------------------------------------------------------
   // Outputs
   // ----------------------------------------------------------------------
   assign done     = done_q;
   assign misalign = misalign_q;
   assign bus_err  = bus_err_q;

   assign m_axi_awid    = ID_WIDTH'(WR_ID);
   assign m_axi_awaddr  = addr_q;
   assign m_axi_awlen   = 8'd0;
   assign m_axi_awsize  = {1'b0, size_q};
   assign m_axi_awburst = 2'b01;
   assign m_axi_awlock  = 1'b0;
   assign m_axi_awcache = 4'd0;
   assign m_axi_awprot  = 3'd0;

   assign m_axi_wdata = wdata_q;
   assign m_axi_wstrb = wstrb_q;
   assign m_axi_wlast = 1'b1;

endmodule
